// File: rtl/sprite_blitter.sv
// Sprite blitter: streams a sprite from ROM into the framebuffer write port
// at (pos_x,pos_y), dropping transparent and off-screen pixels.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   start, pos_x/pos_y copy request and sprite top-left position
//   rom_addr/rom_data  sprite ROM read port (1-cycle read latency)
//   fb_we/fb_addr/     framebuffer write port (registered)
//   fb_data
//   busy, done         copy in progress / one-cycle completion pulse
module sprite_blitter #(
  parameter int          SPR_W  = 40,
  parameter int          SPR_H  = 40,
  parameter int          FB_W   = 640,
  parameter int          FB_H   = 480,
  parameter int          SRC_AW = 16,
  parameter logic [3:0]  TRANSP = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic [SRC_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              fb_we,
  output logic [18:0]       fb_addr,
  output logic [3:0]        fb_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic              drn_q, drn_d;
  logic [SRC_AW-1:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;

  // Position of the pixel whose ROM data arrives this cycle.
  logic              vb_q, vb_d;
  logic [CW-1:0]     col_b_q, col_b_d;
  logic [RW-1:0]     row_b_q, row_b_d;

  logic              fb_we_q, fb_we_d;
  logic [18:0]       fb_addr_q, fb_addr_d;
  logic [3:0]        fb_data_q, fb_data_d;

  logic              last;
  logic [10:0]       sx, sy;
  logic              vis;
  logic [18:0]       lin;

  assign last = (col_q == CW'(SPR_W - 1))
             && (row_q == RW'(SPR_H - 1));

  always_comb begin
    state_d    = state_q;
    drn_d      = drn_q;
    rom_addr_d = rom_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          rom_addr_d = '0;
          col_d      = '0;
          row_d      = '0;
          pos_x_d    = pos_x;
          pos_y_d    = pos_y;
        end
      end
      FETCH: begin
        if (last) begin
          state_d    = DRAIN;
          drn_d      = 1'b0;
          rom_addr_d = '0;
        end else begin
          rom_addr_d = rom_addr_q + SRC_AW'(1);
          if (col_q == CW'(SPR_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (drn_q) state_d = FINISH;
        else       drn_d   = 1'b1;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign vb_d    = (state_q == FETCH);
  assign col_b_d = col_q;
  assign row_b_d = row_q;

  // 11-bit sums so a sprite hanging past the edge is clipped, not wrapped.
  assign sx  = {1'b0, pos_x_q} + 11'(col_b_q);
  assign sy  = {1'b0, pos_y_q} + 11'(row_b_q);
  assign lin = 19'(sy) * 19'(FB_W) + 19'(sx);
  assign vis = (rom_data != TRANSP)
            && (sx < 11'(FB_W))
            && (sy < 11'(FB_H));

  always_comb begin
    fb_we_d   = vb_q && vis;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (vb_q) begin
      fb_addr_d = lin;
      fb_data_d = rom_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      drn_q      <= 1'b0;
      rom_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      vb_q       <= 1'b0;
      col_b_q    <= '0;
      row_b_q    <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      drn_q      <= drn_d;
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vb_q       <= vb_d;
      col_b_q    <= col_b_d;
      row_b_q    <= row_b_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign busy     = (state_q == FETCH) || (state_q == DRAIN);
  assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: a 4x2 instance and a default 40x40 instance
// checked cycle by cycle against a pixel-level reference model.
module tb_sprite_blitter;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        sel;
  logic [9:0]  pos_x, pos_y;

  logic [15:0] ra_s, ra_b;
  logic [3:0]  rd_s, rd_b;
  logic        we_s, we_b;
  logic [18:0] fa_s, fa_b;
  logic [3:0]  fd_s, fd_b;
  logic        busy_s, busy_b;
  logic        done_s, done_b;

  logic [3:0]  rom_mem [0:1599];

  int n_chk;
  int n_fail;

  sprite_blitter #(.SPR_W(4), .SPR_H(2)) u_small (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start & ~sel),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .rom_addr (ra_s),
    .rom_data (rd_s),
    .fb_we    (we_s),
    .fb_addr  (fa_s),
    .fb_data  (fd_s),
    .busy     (busy_s),
    .done     (done_s)
  );

  sprite_blitter u_big (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start & sel),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .rom_addr (ra_b),
    .rom_data (rd_b),
    .fb_we    (we_b),
    .fb_addr  (fa_b),
    .fb_data  (fd_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    rd_s <= rom_mem[ra_s];
    rd_b <= rom_mem[ra_b];
  end

  logic [15:0] o_ra;
  logic        o_we, o_busy, o_done;
  logic [18:0] o_fa;
  logic [3:0]  o_fd;

  assign o_ra   = sel ? ra_b   : ra_s;
  assign o_we   = sel ? we_b   : we_s;
  assign o_fa   = sel ? fa_b   : fa_s;
  assign o_fd   = sel ? fd_b   : fd_s;
  assign o_busy = sel ? busy_b : busy_s;
  assign o_done = sel ? done_b : done_s;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rom_addr", 32'(o_ra), 0);
    chk("rst_fb_we", 32'(o_we), 0);
    chk("rst_fb_addr", 32'(o_fa), 0);
    chk("rst_fb_data", 32'(o_fd), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
  endtask

  // One copy from start at cycle T through done at T+N+3 and one idle
  // cycle after; pulses=1 also fires start at T+4 and on the done cycle.
  task automatic run_copy(input int px, input int py, input bit pulses);
    int w, n;
    w = sel ? 40 : 4;
    n = sel ? 1600 : 8;
    pos_x = 10'(px);
    pos_y = 10'(py);
    start = 1'b1;
    tick();
    start = 1'b0;
    pos_x = 10'($urandom);
    pos_y = 10'($urandom);
    for (int k = 1; k <= n + 3; k++) begin
      int  i;
      int  x, y;
      bit  ewe;
      int  eaddr;
      int  edat;
      i     = k - 3;
      ewe   = 1'b0;
      eaddr = 0;
      edat  = 0;
      if (i >= 0 && i < n) begin
        x     = px + (i % w);
        y     = py + (i / w);
        edat  = int'(rom_mem[i]);
        ewe   = (edat != 0) && (x < 640) && (y < 480);
        eaddr = (y * 640 + x) % 524288;
      end
      chk("busy", 32'(o_busy), 32'(k <= n + 2));
      chk("done", 32'(o_done), 32'(k == n + 3));
      if (k <= n) chk("rom_addr", 32'(o_ra), 32'(k - 1));
      chk("fb_we", 32'(o_we), 32'(ewe));
      if (ewe) begin
        chk("fb_addr", 32'(o_fa), 32'(eaddr));
        chk("fb_data", 32'(o_fd), 32'(edat));
      end
      if (pulses && (k == 4 || k == n + 3)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("post_busy", 32'(o_busy), 0);
    chk("post_done", 32'(o_done), 0);
    chk("post_we", 32'(o_we), 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sel    = 1'b0;
    start  = 1'b0;
    pos_x  = '0;
    pos_y  = '0;
    Reset  = 1'b1;
    for (int j = 0; j < 1600; j++) rom_mem[j] = 4'((j % 15) + 1);
    for (int j = 0; j < 8; j++) rom_mem[j] = 4'(j + 1);
    repeat (3) tick();
    chk_reset_vals();
    sel = 1'b1;
    chk_reset_vals();
    sel   = 1'b0;
    Reset = 1'b0;
    tick();

    run_copy(10, 20, 1'b0);

    rom_mem[2] = 4'h0;
    rom_mem[5] = 4'h0;
    run_copy(10, 20, 1'b0);
    rom_mem[2] = 4'h3;
    rom_mem[5] = 4'h6;

    run_copy(638, 479, 1'b0);

    run_copy(10, 20, 1'b1);
    run_copy(10, 20, 1'b0);

    pos_x = 10'd10;
    pos_y = 10'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_we", 32'(o_we), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_rom_addr", 32'(o_ra), 0);
    chk("mid_rst_done", 32'(o_done), 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("after_rst_done", 32'(o_done), 0);
      chk("after_rst_we", 32'(o_we), 0);
    end
    run_copy(10, 20, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int px, py;
      for (int j = 0; j < 8; j++) rom_mem[j] = 4'($urandom_range(0, 15));
      if (r < 4) begin
        px = $urandom_range(600, 1023);
        py = $urandom_range(460, 1023);
      end else begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
      end
      run_copy(px, py, r[0]);
    end

    sel = 1'b1;
    for (int j = 0; j < 1600; j++) rom_mem[j] = 4'((j % 15) + 1);
    run_copy(0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
